atomrvcore_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit, parametrised in data width, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation per handshake and computes it over a fixed number of cycles with a radix-2 shift-add or restoring-divide datapath. It returns the result with its destination-register tag, and holds the result under downstream back-pressure. While it is busy, the pipeline stalls through `ready_o`/`busy_o`; a flush squashes any in-flight operation.

---
 rtl/atomrvcore_muldiv_unit_if.sv | 35 +++
 rtl/atomrvcore_muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_atomrvcore_muldiv_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/atomrvcore_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M unit.
// Carries no logic; latency is defined by the unit behind the slave modport.
// Back-pressure: ready_o gates requests, ready_i holds a presented result.
interface atomrvcore_muldiv_unit_if #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
);
    // request side
    logic                        valid_i;
    logic                        ready_o;
    logic [2:0]                  op_i;
    logic [DATAWIDTH-1:0]        operand_A;
    logic [DATAWIDTH-1:0]        operand_B;
    logic [REG_ADRESS_WIDTH-1:0] RD_i;
    logic                        flush_i;

    // response side
    logic                        valid_o;
    logic                        ready_i;
    logic [DATAWIDTH-1:0]        result_o;
    logic [REG_ADRESS_WIDTH-1:0] RD_o;
    logic                        busy_o;

    // pipeline side: issues operations, consumes results
    modport master (
        output valid_i, op_i, operand_A, operand_B, RD_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, RD_o, busy_o
    );

    // execute unit side
    modport slave (
        input  valid_i, op_i, operand_A, operand_B, RD_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, RD_o, busy_o
    );
endinterface

// File: rtl/atomrvcore_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: DATAWIDTH+2 edges counting the accept edge; div-by-zero/overflow in 1 edge.
// Back-pressure: ready_o only in IDLE; a result is held in DONE until ready_i, flush squashes.
module atomrvcore_muldiv_unit #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5,
    parameter int CNT_WIDTH        = $clog2(DATAWIDTH)
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    atomrvcore_muldiv_unit_if.slave io
);
    localparam int W = DATAWIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                      state_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [2:0]                  op_q;
    logic [W-1:0]                mcand_q;     // multiplicand magnitude or divisor magnitude
    logic [2*W-1:0]              acc_q;       // {product hi, multiplier} or {remainder, dividend/quotient}
    logic                        neg_res_q;   // negate product / quotient in FIX
    logic                        neg_rem_q;   // negate remainder in FIX
    logic [W-1:0]                result_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_q;
    logic                        valid_q;
    logic                        busy_q;

    // accept-time decode
    logic         is_div;
    logic         a_signed;
    logic         b_signed;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         div_zero;
    logic         div_ovf;
    logic         special;
    logic [W-1:0] special_res;

    // one-iteration datapath
    logic [W:0]     mul_sum;
    logic [2*W:0]   mul_ext;
    logic [2*W-1:0] mul_next;
    logic [2*W:0]   div_shl;
    logic [W:0]     div_rem_sh;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;

    // sign correction and result selection
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_res;

    // Operand signedness, magnitudes and the special cases that bypass iteration
    always_comb begin
        is_div   = io.op_i[2];
        // MULH, MULHSU, DIV, REM take A signed; MULH, DIV, REM take B signed
        a_signed = (io.op_i == 3'b001) || (io.op_i == 3'b010) ||
                   (io.op_i == 3'b100) || (io.op_i == 3'b110);
        b_signed = (io.op_i == 3'b001) || (io.op_i == 3'b100) || (io.op_i == 3'b110);
        a_neg    = a_signed & io.operand_A[W-1];
        b_neg    = b_signed & io.operand_B[W-1];
        // the most-negative value negates to itself, which is its correct unsigned magnitude
        a_mag    = a_neg ? -io.operand_A : io.operand_A;
        b_mag    = b_neg ? -io.operand_B : io.operand_B;

        div_zero = is_div && (io.operand_B == '0);
        div_ovf  = is_div && !io.op_i[0] && (io.operand_A == MOST_NEG) && (io.operand_B == '1);
        special  = div_zero || div_ovf;

        special_res = '0;
        if (div_zero) begin
            special_res = io.op_i[1] ? io.operand_A : '1;
        end else if (div_ovf) begin
            special_res = io.op_i[1] ? '0 : io.operand_A;
        end
    end

    // One radix-2 step of each algorithm; CALC picks the one matching the latched op
    always_comb begin
        // multiply: conditionally add multiplicand into the high half, then shift right
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
        mul_ext  = acc_q[0] ? {mul_sum, acc_q[W-1:0]} : {1'b0, acc_q};
        mul_next = mul_ext[2*W:1];

        // restoring divide: shift in the next dividend bit, trial-subtract the divisor
        div_shl    = {acc_q, 1'b0};
        div_rem_sh = div_shl[2*W:W];
        div_diff   = div_rem_sh - {1'b0, mcand_q};
        if (!div_diff[W]) begin
            div_next = {div_diff[W-1:0], div_shl[W-1:1], 1'b1};
        end else begin
            div_next = {div_rem_sh[W-1:0], div_shl[W-1:0]};
        end
    end

    // Final sign fix-up and half/quotient/remainder selection
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -(acc_q[W-1:0]) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? -(acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    // Control FSM with datapath registers; flush overrides every other transition
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (io.flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.valid_i) begin
                        op_q      <= io.op_i;
                        rd_q      <= io.RD_i;
                        cnt_q     <= CNT_WIDTH'(W - 1);
                        mcand_q   <= is_div ? b_mag : a_mag;
                        acc_q     <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        busy_q    <= 1'b1;
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (io.ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ready_o decodes state only, so valid_i never reaches it combinationally
    assign io.ready_o  = (state_q == IDLE);
    assign io.valid_o  = valid_q;
    assign io.busy_o   = busy_q;
    assign io.result_o = result_q;
    assign io.RD_o     = rd_q;
endmodule

// File: tb/tb_atomrvcore_muldiv_unit.sv
// Directed bench for the iterative multiply/divide unit at DATAWIDTH=32.
// Latency is counted in rising edges including the accept edge.
// Covers back-pressure hold, flush and asynchronous reset mid-operation.
module tb_atomrvcore_muldiv_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    atomrvcore_muldiv_unit_if #(.DATAWIDTH(32), .REG_ADRESS_WIDTH(5)) bus ();

    atomrvcore_muldiv_unit #(.DATAWIDTH(32), .REG_ADRESS_WIDTH(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus)
    );

    always #5 clk = ~clk;

    // present one request so that it is accepted on the next rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.op_i      = op;
        bus.operand_A = a;
        bus.operand_B = b;
        bus.RD_i      = rd;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    // edges including the accept edge until valid_o is seen; -1 on timeout
    task automatic wait_valid(output int edges);
        int n = 0;
        while (bus.valid_o !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        edges = (bus.valid_o === 1'b1) ? n + 1 : -1;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int edges);
        issue(op, a, b, rd);
        wait_valid(edges);
        res = bus.result_o;
        rdo = bus.RD_o;
        handshake();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.result_o !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        checks++; if (bus.RD_o !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", bus.RD_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] t; int e;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, r, t, e);
        checks++; if (r !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result got %h want ffffffeb", r); end
        checks++; if (t !== 5'd9) begin fails++; $display("FAIL mul_rd got %0d want 9", t); end
        checks++; if (e !== 34) begin fails++; $display("FAIL mul_latency got %0d want 34", e); end
    endtask

    task automatic test_mul_high();
        logic [31:0] r; logic [4:0] t; int e;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, r, t, e);
        checks++; if (r !== 32'h4000_0000) begin fails++; $display("FAIL mulh got %h want 40000000", r); end
        run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, r, t, e);
        checks++; if (r !== 32'h4000_0000) begin fails++; $display("FAIL mulhu got %h want 40000000", r); end
        run_op(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3, r, t, e);
        checks++; if (r !== 32'hC000_0000) begin fails++; $display("FAIL mulhsu got %h want c0000000", r); end
        checks++; if (e !== 34) begin fails++; $display("FAIL mulhsu_latency got %0d want 34", e); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [4:0] t; int e;
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, r, t, e);
        checks++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf got %h want 80000000", r); end
        checks++; if (e !== 1) begin fails++; $display("FAIL div_ovf_latency got %0d want 1", e); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, r, t, e);
        checks++; if (r !== 32'h0) begin fails++; $display("FAIL rem_ovf got %h want 0", r); end
        checks++; if (e !== 1) begin fails++; $display("FAIL rem_ovf_latency got %0d want 1", e); end
        run_op(3'b101, 32'd5, 32'd0, 5'd6, r, t, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_zero got %h want ffffffff", r); end
        checks++; if (e !== 1) begin fails++; $display("FAIL divu_zero_latency got %0d want 1", e); end
        run_op(3'b111, 32'd5, 32'd0, 5'd7, r, t, e);
        checks++; if (r !== 32'd5) begin fails++; $display("FAIL remu_zero got %h want 5", r); end
        checks++; if (e !== 1) begin fails++; $display("FAIL remu_zero_latency got %0d want 1", e); end
        checks++; if (t !== 5'd7) begin fails++; $display("FAIL remu_zero_rd got %0d want 7", t); end
    endtask

    task automatic test_signed_div();
        logic [31:0] r; logic [4:0] t; int e;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, r, t, e);
        checks++; if (r !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg got %h want fffffffd", r); end
        checks++; if (e !== 34) begin fails++; $display("FAIL div_neg_latency got %0d want 34", e); end
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, r, t, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_neg got %h want ffffffff", r); end
    endtask

    task automatic test_back_to_back();
        int e;
        bus.ready_i = 1'b0;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        wait_valid(e);
        checks++; if (e !== 34) begin fails++; $display("FAIL bp_latency got %0d want 34", e); end
        // result and tag must hold while downstream stalls
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.result_o !== 32'hFFFF_FFFE || bus.RD_o !== 5'd17 ||
                bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got res=%h rd=%0d rdy=%b vld=%b want fffffffe 17 0 1",
                         i, bus.result_o, bus.RD_o, bus.ready_o, bus.valid_o);
            end
        end
        handshake();
        checks++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            fails++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", bus.ready_o, bus.valid_o); end
        // next op presented in the single IDLE cycle, accepted on the following edge
        bus.valid_i   = 1'b1;
        bus.op_i      = 3'b101;
        bus.operand_A = 32'd100;
        bus.operand_B = 32'd7;
        bus.RD_i      = 5'd18;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy_o); end
        wait_valid(e);
        checks++; if (bus.result_o !== 32'd14) begin fails++; $display("FAIL b2b_divu got %h want e", bus.result_o); end
        checks++; if (bus.RD_o !== 5'd18) begin fails++; $display("FAIL b2b_rd got %0d want 18", bus.RD_o); end
        handshake();
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] t; int e;
        logic seen = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 5'd3);
        repeat (14) @(posedge clk);
        // flush lands on the 15th CALC edge together with a new request
        @(negedge clk);
        bus.flush_i   = 1'b1;
        bus.valid_i   = 1'b1;
        bus.op_i      = 3'b100;
        bus.operand_A = 32'd9;
        bus.operand_B = 32'd3;
        bus.RD_i      = 5'd21;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            fails++; $display("FAIL flush_idle got rdy=%b busy=%b want 1 0", bus.ready_o, bus.busy_o); end
        checks++; if (bus.RD_o !== 5'd3) begin fails++; $display("FAIL flush_no_accept got rd=%0d want 3", bus.RD_o); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 seen = seen | bus.valid_o | bus.busy_o;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_quiet got activity=%b want 0", seen); end
        run_op(3'b000, 32'd3, 32'd5, 5'd12, r, t, e);
        checks++; if (r !== 32'd15 || e !== 34) begin
            fails++; $display("FAIL flush_recover got %h lat %0d want f lat 34", r, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [4:0] t; int e;
        logic seen = 1'b0;
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd30);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++; $display("FAIL rst_mid_ctl got rdy=%b vld=%b busy=%b want 1 0 0",
                              bus.ready_o, bus.valid_o, bus.busy_o); end
        checks++; if (bus.result_o !== 32'h0) begin fails++; $display("FAIL rst_mid_result got %h want 0", bus.result_o); end
        checks++; if (bus.RD_o !== 5'd0) begin fails++; $display("FAIL rst_mid_rd got %0d want 0", bus.RD_o); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 seen = seen | bus.valid_o;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_no_result got %b want 0", seen); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd31, r, t, e);
        checks++; if (r !== 32'd1) begin fails++; $display("FAIL rst_recover got %h want 1", r); end
    endtask

    initial begin
        bus.valid_i   = 1'b0;
        bus.op_i      = 3'b000;
        bus.operand_A = 32'h0;
        bus.operand_B = 32'h0;
        bus.RD_i      = 5'd0;
        bus.flush_i   = 1'b0;
        bus.ready_i   = 1'b0;
        test_reset();
        test_mul();
        test_mul_high();
        test_special();
        test_signed_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
